// File: rtl/toy_pack.sv
// Shared widths and request/response records for the DTCM initiator.
package toy_pack;

   localparam int ADDR_WIDTH     = 32;
   localparam int BUS_DATA_WIDTH = 32;
   localparam int FETCH_SB_WIDTH = 4;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]       addr;
      logic                        wr;
      logic [BUS_DATA_WIDTH-1:0]   wdata;
      logic [BUS_DATA_WIDTH/8-1:0] wstrb;
      logic [FETCH_SB_WIDTH-1:0]   sb;
   } dtcm_req_t;

   typedef struct packed {
      logic [BUS_DATA_WIDTH-1:0] data;
      logic [FETCH_SB_WIDTH-1:0] sb;
   } dtcm_rsp_t;

endpackage

// File: rtl/toy_dtcm_rsp_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; a pop on empty is ignored,
// push and pop may coincide in any occupancy state (no bypass).
module toy_dtcm_rsp_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     pop_data,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = 1;

   logic [PW:0] wr_ptr_q, rd_ptr_q;
   logic        pop_ok;
   T            mem_q [DEPTH];

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push)   wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/toy_dtcm_master.sv
// LSU-side initiator for the dtcm_mem_* port: credit-gated issue, fixed-latency
// read tracking, buffered responses. Optional sideband check: TOY_DTCM_SB_CHECK_EN.
module toy_dtcm_master
   import toy_pack::*;
#(
   parameter int RD_LAT    = 2,
   parameter int RSP_DEPTH = 4,
   parameter int ADDR_W    = ADDR_WIDTH,
   parameter int DATA_W    = BUS_DATA_WIDTH,
   parameter int SB_W      = FETCH_SB_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_vld,
   output logic                req_rdy,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_wr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [SB_W-1:0]     req_sb,
   output logic                rsp_vld,
   input  logic                rsp_rdy,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [SB_W-1:0]     rsp_sb,
   output logic                idle,
   output logic                sb_err,
   output logic                dtcm_mem_en,
   output logic                dtcm_mem_wr_en,
   output logic [ADDR_W-1:0]   dtcm_mem_addr,
   output logic [DATA_W-1:0]   dtcm_mem_wr_data,
   output logic [DATA_W/8-1:0] dtcm_mem_wr_byte_en,
   output logic [SB_W-1:0]     dtcm_mem_req_sideband,
   input  logic [DATA_W-1:0]   dtcm_mem_rd_data,
   input  logic [SB_W-1:0]     dtcm_mem_ack_sideband
);

   localparam int CW = $clog2(RSP_DEPTH) + 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);
   localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

   dtcm_req_t         req;
   dtcm_rsp_t         push_rsp, head_rsp;
   logic              fire, ld_fire, rsp_pop, capture;
   logic [CW-1:0]     credit_q, credit_d;
   logic [RD_LAT-1:0] trk_vld_q, trk_vld_d;
   logic [SB_W-1:0]   trk_sb_q [RD_LAT];
   logic [SB_W-1:0]   trk_sb_d [RD_LAT];
   logic              fifo_empty, unused_fifo_full;

   assign req = {req_addr, req_wr, req_wdata, req_wstrb, req_sb};

   assign req_rdy = ~rst & (credit_q != '0);
   assign fire    = req_vld & req_rdy;
   assign ld_fire = fire & ~req.wr;
   assign rsp_pop = rsp_vld & rsp_rdy;

   assign dtcm_mem_en           = fire;
   assign dtcm_mem_wr_en        = fire & req.wr;
   assign dtcm_mem_addr         = req.addr;
   assign dtcm_mem_wr_data      = req.wdata;
   assign dtcm_mem_wr_byte_en   = req.wstrb;
   assign dtcm_mem_req_sideband = req.sb;

   // One credit per response slot, so a tracked read always finds room.
   always_comb begin
      credit_d = credit_q;
      if (ld_fire & ~rsp_pop)      credit_d = credit_q - CREDIT_ONE;
      else if (~ld_fire & rsp_pop) credit_d = credit_q + CREDIT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) credit_q <= CREDIT_MAX;
      else     credit_q <= credit_d;
   end

   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_trk
         if (gi == 0) begin : g_head
            assign trk_vld_d[gi] = ld_fire;
            assign trk_sb_d[gi]  = req.sb;
         end else begin : g_tail
            assign trk_vld_d[gi] = trk_vld_q[gi-1];
            assign trk_sb_d[gi]  = trk_sb_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) trk_vld_q <= '0;
      else     trk_vld_q <= trk_vld_d;
      trk_sb_q <= trk_sb_d;
   end

   assign capture  = trk_vld_q[RD_LAT-1];
   assign push_rsp = {dtcm_mem_rd_data, trk_sb_q[RD_LAT-1]};

   toy_dtcm_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (dtcm_rsp_t)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (capture),
      .push_data (push_rsp),
      .pop       (rsp_pop),
      .pop_data  (head_rsp),
      .full      (unused_fifo_full),
      .empty     (fifo_empty)
   );

   assign rsp_vld  = ~fifo_empty;
   assign rsp_data = head_rsp.data;
   assign rsp_sb   = head_rsp.sb;
   assign idle     = (credit_q == CREDIT_MAX);

`ifdef TOY_DTCM_SB_CHECK_EN
   logic sb_err_q, sb_err_d, sb_mis;

   assign sb_mis   = capture & (dtcm_mem_ack_sideband != trk_sb_q[RD_LAT-1]);
   assign sb_err_d = sb_err_q | sb_mis;
   assign sb_err   = sb_err_q;

   always_ff @(posedge clk) begin
      if (rst) sb_err_q <= 1'b0;
      else     sb_err_q <= sb_err_d;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && sb_mis)
         $error("toy_dtcm_master: ack sideband %0h, expected %0h", dtcm_mem_ack_sideband, trk_sb_q[RD_LAT-1]);
   end
`endif
`else
   logic unused_ack_sb;

   assign unused_ack_sb = ^dtcm_mem_ack_sideband;
   assign sb_err        = 1'b0;
`endif

endmodule

// File: tb/tb_toy_dtcm_master.sv
// Self-checking bench for toy_dtcm_master: directed scenarios plus random traffic,
// scored against a queue-based response model and a small fixed-latency memory.
module tb_toy_dtcm_master;

   localparam int RD_LAT = 2;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_vld, req_rdy, req_wr;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb, req_sb;
   logic        rsp_vld, rsp_rdy;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_sb;
   logic        idle, sb_err;
   logic        dtcm_mem_en, dtcm_mem_wr_en;
   logic [31:0] dtcm_mem_addr, dtcm_mem_wr_data, dtcm_mem_rd_data;
   logic [3:0]  dtcm_mem_wr_byte_en, dtcm_mem_req_sideband, dtcm_mem_ack_sideband;

   int checks = 0;
   int errors = 0;

   toy_dtcm_master dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_vld               (req_vld),
      .req_rdy               (req_rdy),
      .req_addr              (req_addr),
      .req_wr                (req_wr),
      .req_wdata             (req_wdata),
      .req_wstrb             (req_wstrb),
      .req_sb                (req_sb),
      .rsp_vld               (rsp_vld),
      .rsp_rdy               (rsp_rdy),
      .rsp_data              (rsp_data),
      .rsp_sb                (rsp_sb),
      .idle                  (idle),
      .sb_err                (sb_err),
      .dtcm_mem_en           (dtcm_mem_en),
      .dtcm_mem_wr_en        (dtcm_mem_wr_en),
      .dtcm_mem_addr         (dtcm_mem_addr),
      .dtcm_mem_wr_data      (dtcm_mem_wr_data),
      .dtcm_mem_wr_byte_en   (dtcm_mem_wr_byte_en),
      .dtcm_mem_req_sideband (dtcm_mem_req_sideband),
      .dtcm_mem_rd_data      (dtcm_mem_rd_data),
      .dtcm_mem_ack_sideband (dtcm_mem_ack_sideband)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory: 64 words, two-cycle read latency, sideband optionally overridden.
   logic [31:0] mem [0:63];
   logic [31:0] rd_p1, rd_p2;
   logic [3:0]  sb_p1, sb_p2;
   logic        corrupt_en;
   logic [3:0]  corrupt_sb;

   function automatic logic [31:0] init_word(input int i);
      return (i == 16) ? 32'hDEADBEEF : (32'hA5A5_0000 + 32'(i));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (dtcm_mem_en && dtcm_mem_wr_en) begin
         for (int b = 0; b < 4; b++)
            if (dtcm_mem_wr_byte_en[b]) mem[dtcm_mem_addr[7:2]][8*b +: 8] <= dtcm_mem_wr_data[8*b +: 8];
      end
      rd_p1 <= (dtcm_mem_en && !dtcm_mem_wr_en) ? mem[dtcm_mem_addr[7:2]] : 32'hBAD0_BAD0;
      sb_p1 <= corrupt_en ? corrupt_sb : dtcm_mem_req_sideband;
      rd_p2 <= rd_p1;
      sb_p2 <= sb_p1;
   end
   assign dtcm_mem_rd_data      = rd_p2;
   assign dtcm_mem_ack_sideband = sb_p2;

   // Model: each accepted load becomes visible RD_LAT+1 cycles later, in order,
   // and holds one of DEPTH slots until popped.
   typedef struct {
      int unsigned rdy_cyc;
      logic [31:0] data;
      logic [3:0]  sb;
      bit          bad;
   } exp_t;

   exp_t        exp_q [$];
   int unsigned cyc = 0;
   int          wr_cnt = 0;
   bit          exp_err = 1'b0;

   always @(negedge clk) begin
      bit exp_rdy, exp_fire, exp_vld;
      cyc++;
      if (rst) begin
         chk("rdy_in_rst", {63'd0, req_rdy}, 64'd0);
         chk("en_in_rst", {63'd0, dtcm_mem_en}, 64'd0);
         exp_q.delete();
         exp_err = 1'b0;
      end else begin
         exp_rdy  = (exp_q.size() < DEPTH);
         exp_fire = req_vld && exp_rdy;
         exp_vld  = (exp_q.size() > 0) && (exp_q[0].rdy_cyc <= cyc);
         chk("req_rdy", {63'd0, req_rdy}, {63'd0, exp_rdy});
         chk("mem_en", {63'd0, dtcm_mem_en}, {63'd0, exp_fire});
         chk("mem_wr_en", {63'd0, dtcm_mem_wr_en}, {63'd0, exp_fire && req_wr});
         if (exp_fire) begin
            chk("mem_addr", {32'd0, dtcm_mem_addr}, {32'd0, req_addr});
            chk("mem_wdata", {32'd0, dtcm_mem_wr_data}, {32'd0, req_wdata});
            chk("mem_wstrb", {60'd0, dtcm_mem_wr_byte_en}, {60'd0, req_wstrb});
            chk("mem_req_sb", {60'd0, dtcm_mem_req_sideband}, {60'd0, req_sb});
         end
         chk("rsp_vld", {63'd0, rsp_vld}, {63'd0, exp_vld});
         if (exp_vld) begin
            chk("rsp_data", {32'd0, rsp_data}, {32'd0, exp_q[0].data});
            chk("rsp_sb", {60'd0, rsp_sb}, {60'd0, exp_q[0].sb});
         end
         chk("idle", {63'd0, idle}, {63'd0, exp_q.size() == 0});
`ifdef TOY_DTCM_SB_CHECK_EN
         foreach (exp_q[i]) if (exp_q[i].rdy_cyc == cyc && exp_q[i].bad) exp_err = 1'b1;
`endif
         chk("sb_err", {63'd0, sb_err}, {63'd0, exp_err});
         if (dtcm_mem_wr_en) wr_cnt++;
         if (exp_vld && rsp_rdy) void'(exp_q.pop_front());
         if (exp_fire && !req_wr)
            exp_q.push_back('{rdy_cyc: cyc + RD_LAT + 1, data: mem[req_addr[7:2]], sb: req_sb,
                              bad: corrupt_en && (corrupt_sb != req_sb)});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      req_vld   = v;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = 4'hF;
      req_sb    = s;
   endtask

   initial begin
      int n;
      int wr0;
      rst        = 1'b1;
      rsp_rdy    = 1'b1;
      corrupt_en = 1'b0;
      corrupt_sb = 4'h0;
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rsp_vld", {63'd0, rsp_vld}, 64'd0);
      chk("reset_idle", {63'd0, idle}, 64'd1);
      chk("reset_sb_err", {63'd0, sb_err}, 64'd0);
      chk("reset_req_rdy", {63'd0, req_rdy}, 64'd1);

      // Single load, response three cycles after fire.
      step();
      drive(1, 0, 32'h40, 32'h0, 4'h5);
      step();
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      step();
      step();
      @(negedge clk);
      chk("t1_rsp_vld_fire3", {63'd0, rsp_vld}, 64'd1);
      chk("t1_rsp_data", {32'd0, rsp_data}, 64'hDEADBEEF);
      chk("t1_rsp_sb", {60'd0, rsp_sb}, 64'h5);
      step();
      @(negedge clk);
      chk("t1_idle_after_pop", {63'd0, idle}, 64'd1);

      // Store then load of the same word.
      step();
      wr0 = wr_cnt;
      drive(1, 1, 32'h80, 32'h11223344, 4'h0);
      step();
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("t2_store_no_credit", {63'd0, idle}, 64'd1);
      step();
      drive(1, 0, 32'h80, 32'h0, 4'h1);
      step();
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      step();
      step();
      @(negedge clk);
      chk("t2_load_data", {32'd0, rsp_data}, 64'h11223344);
      chk("t2_wr_pulses", 64'(wr_cnt - wr0), 64'd1);

      // Credit exhaustion with responses held back.
      step();
      rsp_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 32'(i * 4), 32'h0, 4'(i));
         step();
      end
      drive(1, 0, 32'h10, 32'h0, 4'h4);
      repeat (5) step();
      @(negedge clk);
      chk("t3_rdy_low_full", {63'd0, req_rdy}, 64'd0);
      chk("t3_not_idle", {63'd0, idle}, 64'd0);
      step();
      rsp_rdy = 1'b1;
      @(negedge clk);
      chk("t3_rdy_low_at_pop", {63'd0, req_rdy}, 64'd0);
      chk("t3_first_sb", {60'd0, rsp_sb}, 64'h0);
      step();
      @(negedge clk);
      chk("t3_rdy_after_pop", {63'd0, req_rdy}, 64'd1);
      step();
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      repeat (8) step();

      // Back-to-back loads with a free-running consumer.
      n = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, $urandom_range(0, 63) * 4, 32'h0, 4'(i));
         @(negedge clk);
         if (req_rdy) n++;
         step();
      end
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      chk("t4_accept_count", 64'(n), 64'd20);
      repeat (6) step();

      // Random mixed traffic and backpressure.
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 63) * 4,
               $urandom, 4'($urandom));
         req_wstrb = 4'($urandom);
         rsp_rdy   = ($urandom_range(0, 9) < 7);
         step();
      end
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      rsp_rdy = 1'b1;
      repeat (10) step();

      // Reset with two loads in flight.
      drive(1, 0, 32'h20, 32'h0, 4'h3);
      step();
      drive(1, 0, 32'h24, 32'h0, 4'h4);
      step();
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rsp_vld_after_rst", {63'd0, rsp_vld}, 64'd0);
      chk("t5_idle_after_rst", {63'd0, idle}, 64'd1);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         @(negedge clk);
         if (rsp_vld) n++;
      end
      chk("t5_no_stale_rsp", 64'(n), 64'd0);

      // Sideband mismatch on a single load.
      step();
      corrupt_en = 1'b1;
      corrupt_sb = 4'h7;
      drive(1, 0, 32'h8, 32'h0, 4'h2);
      step();
      corrupt_en = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      repeat (4) step();
      @(negedge clk);
`ifdef TOY_DTCM_SB_CHECK_EN
      chk("t6_sb_err_set", {63'd0, sb_err}, 64'd1);
      repeat (5) step();
      @(negedge clk);
      chk("t6_sb_err_sticky", {63'd0, sb_err}, 64'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_sb_err_cleared", {63'd0, sb_err}, 64'd0);
`else
      chk("t6_sb_err_off", {63'd0, sb_err}, 64'd0);
`endif
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
